// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Opcode map of the external ALU, MUL macro-op code and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_LSH = 4'd6,
        OP_RSH = 4'd7,
        OP_SLT = 4'd8,
        OP_SEQ = 4'd9
    } op_mne;

    // ALU opcodes are contiguous from zero; anything above OP_LAST is not an ALU op.
    localparam logic [3:0] OP_LAST = OP_SEQ;
    localparam logic [3:0] MUL_OP  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_M_CHK = 3'd2,
        ST_M_ADD = 3'd3,
        ST_M_SHL = 3'd4,
        ST_M_SHR = 3'd5,
        ST_RESP  = 3'd6
    } seq_state;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Issues requests to an external combinational ALU and returns
//               registered responses; adds a shift-and-add MUL macro-op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           ReqValid,
    output logic           ReqReady,
    input  logic [OPW-1:0] ReqOp,
    input  logic [W-1:0]   ReqA,
    input  logic [W-1:0]   ReqB,
    output logic [W-1:0]   AluA,
    output logic [W-1:0]   AluB,
    output logic [OPW-1:0] AluOp,
    input  logic [W-1:0]   AluOut,
    input  logic           AluCond,
    output logic           RspValid,
    input  logic           RspReady,
    output logic [W-1:0]   RspData,
    output logic           RspCond,
    output logic           RspErr
);

    seq_state       state;
    logic [OPW-1:0] op;
    logic [W-1:0]   acc;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   rsp_data;
    logic           rsp_cond;
    logic           rsp_err;

    logic accept;
    logic req_is_alu;
    logic req_is_mul;

    assign ReqReady   = (state == ST_IDLE) && !Reset;
    assign accept     = ReqValid && ReqReady;
    assign req_is_alu = (ReqOp <= OPW'(OP_LAST));
    assign req_is_mul = (ReqOp == OPW'(MUL_OP));

    assign RspValid = (state == ST_RESP);
    assign RspData  = rsp_data;
    assign RspCond  = rsp_cond;
    assign RspErr   = rsp_err;

    // The ALU idles on ADD 0,0 so it never decodes an illegal opcode.
    always_comb begin
        AluOp = OPW'(OP_ADD);
        AluA  = '0;
        AluB  = '0;
        case (state)
            ST_EXEC: begin
                AluOp = op;
                AluA  = a;
                AluB  = b;
            end
            ST_M_ADD: begin
                AluA = acc;
                AluB = a;
            end
            ST_M_SHL: begin
                AluOp = OPW'(OP_LSH);
                AluA  = a;
                AluB  = W'(1);
            end
            ST_M_SHR: begin
                AluOp = OPW'(OP_RSH);
                AluA  = b;
                AluB  = W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            op       <= '0;
            acc      <= '0;
            a        <= '0;
            b        <= '0;
            rsp_data <= '0;
            rsp_cond <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op  <= ReqOp;
                        a   <= ReqA;
                        b   <= ReqB;
                        acc <= '0;
                        if (req_is_alu) begin
                            state <= ST_EXEC;
                        end else if (req_is_mul) begin
                            state <= ST_M_CHK;
                        end else begin
                            rsp_data <= '0;
                            rsp_cond <= 1'b0;
                            rsp_err  <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_data <= AluOut;
                    rsp_cond <= AluCond;
                    rsp_err  <= 1'b0;
                    state    <= ST_RESP;
                end
                // Multiplier bit b[0] selects whether this round adds the shifted multiplicand.
                ST_M_CHK: begin
                    if (b == '0) begin
                        rsp_data <= acc;
                        rsp_cond <= 1'b0;
                        rsp_err  <= 1'b0;
                        state    <= ST_RESP;
                    end else if (b[0]) begin
                        state <= ST_M_ADD;
                    end else begin
                        state <= ST_M_SHL;
                    end
                end
                ST_M_ADD: begin
                    acc   <= AluOut;
                    state <= ST_M_SHL;
                end
                ST_M_SHL: begin
                    a     <= AluOut;
                    state <= ST_M_SHR;
                end
                ST_M_SHR: begin
                    b     <= AluOut;
                    state <= ST_M_CHK;
                end
                ST_RESP: begin
                    if (RspReady) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed scoreboard bench for alu_sequencer with a behavioural
//               ALU wired to its ALU port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       cond;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_cond;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_cond;
    logic       rsp_err;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_sequencer #(.W(8), .OPW(4)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .ReqValid (req_valid),
        .ReqReady (req_ready),
        .ReqOp    (req_op),
        .ReqA     (req_a),
        .ReqB     (req_b),
        .AluA     (alu_a),
        .AluB     (alu_b),
        .AluOp    (alu_op),
        .AluOut   (alu_out),
        .AluCond  (alu_cond),
        .RspValid (rsp_valid),
        .RspReady (rsp_ready),
        .RspData  (rsp_data),
        .RspCond  (rsp_cond),
        .RspErr   (rsp_err)
    );

    // Reference ALU: Cond is carry for ADD, borrow for SUB, the result for SLT/SEQ.
    always_comb begin
        alu_out  = '0;
        alu_cond = 1'b0;
        case (alu_op)
            OP_ADD: {alu_cond, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: begin alu_out = alu_a - alu_b; alu_cond = (alu_a < alu_b); end
            OP_AND: alu_out = alu_a & alu_b;
            OP_OR:  alu_out = alu_a | alu_b;
            OP_XOR: alu_out = alu_a ^ alu_b;
            OP_NOT: alu_out = ~alu_a;
            OP_LSH: alu_out = alu_a << alu_b[2:0];
            OP_RSH: alu_out = alu_a >> alu_b[2:0];
            OP_SLT: begin alu_cond = (alu_a < alu_b);  alu_out = {7'd0, alu_cond}; end
            OP_SEQ: begin alu_cond = (alu_a == alu_b); alu_out = {7'd0, alu_cond}; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert (alu_op <= OP_LAST) else begin
                errors++;
                $error("FAIL alu_op_legal observed=%0h expected<=%0h", alu_op, OP_LAST);
            end
        end
    end

    function automatic int mul_lat(input logic [7:0] m);
        int   lat = 2;
        logic [7:0] v = m;
        while (v != 8'd0) begin
            lat += v[0] ? 4 : 3;
            v = v >> 1;
        end
        return lat;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, rsp_data, e.data);
            chk({tag, "_cond"}, rsp_cond, e.cond);
            chk({tag, "_err"},  rsp_err,  e.err);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Drive one request, check response latency (cycles after accept), hold, then pop.
    task automatic send(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ed, input logic ec,
                        input logic ee, input int lat);
        int n;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_ready"}, req_ready, 1'b1);
        sb.push_back('{data: ed, cond: ec, err: ee});
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, n, lat);
        pop_check(tag);
        handshake();
        chk({tag, "_valid_drop"}, rsp_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] held_data;
        logic       held_cond;
        logic       seen;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_data",  rsp_data,  8'h00);
        chk("rst_cond",  rsp_cond,  1'b0);
        chk("rst_err",   rsp_err,   1'b0);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_aluop", alu_op, OP_ADD);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1'b1);

        send("add",   OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 2);
        send("slt",   OP_SLT, 8'd3,  8'd5,  8'h01, 1'b1, 1'b0, 2);
        send("seq_eq", OP_SEQ, 8'd4, 8'd4,  8'h01, 1'b1, 1'b0, 2);
        send("seq_ne", OP_SEQ, 8'd4, 8'd5,  8'h00, 1'b0, 1'b0, 2);
        send("not",   OP_NOT, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 2);

        send("mul3x5",     MUL_OP, 8'd3,   8'd5,   8'd15,  1'b0, 1'b0, 13);
        send("mul9x0",     MUL_OP, 8'd9,   8'd0,   8'd0,   1'b0, 1'b0, 2);
        send("mul16x17",   MUL_OP, 8'd16,  8'd17,  8'h10,  1'b0, 1'b0, mul_lat(8'd17));
        send("mul255x255", MUL_OP, 8'd255, 8'd255, 8'h01,  1'b0, 1'b0, mul_lat(8'd255));

        // Backpressure with a queued request behind the held response.
        req_op = OP_ADD; req_a = 8'd10; req_b = 8'd20; req_valid = 1'b1;
        sb.push_back('{data: 8'd30, cond: 1'b0, err: 1'b0});
        @(posedge clk); #1;
        req_op = OP_ADD; req_a = 8'd1; req_b = 8'd2;
        @(posedge clk); #1;
        chk("bp_valid", rsp_valid, 1'b1);
        held_data = rsp_data;
        held_cond = rsp_cond;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_hold_data",  rsp_data,  held_data);
            chk("bp_hold_cond",  rsp_cond,  held_cond);
            chk("bp_hold_ready", req_ready, 1'b0);
        end
        pop_check("bp");
        handshake();
        chk("bp_after_hs_valid", rsp_valid, 1'b0);
        chk("bp_after_hs_ready", req_ready, 1'b1);
        sb.push_back('{data: 8'd3, cond: 1'b0, err: 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_pending_taken", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("bp_pending_valid", rsp_valid, 1'b1);
        pop_check("bp_pending");
        handshake();

        for (int c = 10; c < 15; c++) begin
            send("illegal", 4'(c), 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1, 1);
        end
        send("add_after_err", OP_ADD, 8'd2, 8'd3, 8'd5, 1'b0, 1'b0, 2);

        // Reset in M_SHL of MUL 200x7 discards the operation.
        req_op = MUL_OP; req_a = 8'd200; req_b = 8'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_shl", alu_op, OP_LSH);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_ready", req_ready, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_rsp", seen, 1'b0);
        send("sub_after_abort", OP_SUB, 8'd5, 8'd7, 8'hFE, 1'b1, 1'b0, 2);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
